// File: rtl/csr_file_pkg.sv
// Shared CSR encodings for the writeback-stage CSR file: write-select
// codes and the addresses of the CSRs this core implements.
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_ZERO = 2'd0,
    CSR_REG  = 2'd1,
    CSR_IMM  = 2'd2
  } csr_sel_e;

  localparam logic [11:0] CSR_TOHOST   = 12'h51E;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_TIME     = 12'hC01;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_TIMEH    = 12'hC81;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;

  // Encoding 3 is reserved and behaves like CSR_ZERO.
  function automatic logic is_write_sel(input logic [1:0] sel);
    return (sel == CSR_REG) || (sel == CSR_IMM);
  endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with an increment enable; the full-width add
// keeps the low-to-high carry inside a single edge.
module counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [63:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_file.sv
// Writeback-stage CSR file: tohost register with host strobe, cycle/time
// and instret counters, combinational read-before-write port.
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [11:0] TOHOST_ADDR  = CSR_TOHOST,
  parameter logic [31:0] TOHOST_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  csr_sel,
  input  logic [31:0] inst_W,
  input  logic [31:0] rs1_data_W,
  input  logic        retire_W,
  input  logic        stall_W,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        tohost_wr,
  output logic        csr_illegal
);

  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic        wr_sel;
  logic        wr_en;
  logic        tohost_we;
  logic [31:0] wr_data;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic        unused_inst;

  assign csr_addr    = inst_W[31:20];
  assign zimm        = inst_W[19:15];
  assign unused_inst = ^inst_W[14:0];

  assign wr_sel    = is_write_sel(csr_sel);
  assign wr_en     = wr_sel && !stall_W;
  assign tohost_we = wr_en && (csr_addr == TOHOST_ADDR);
  assign wr_data   = (csr_sel == CSR_IMM) ? {27'b0, zimm} : rs1_data_W;

  // Only tohost is writable, so any other address under a write select is
  // illegal whether it is unknown or read-only; stall does not mask it.
  assign csr_illegal = wr_sel && (csr_addr != TOHOST_ADDR);

  counter64 u_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .count (cycle_cnt)
  );

  counter64 u_instret (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire_W && !stall_W),
    .count (instret_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tohost    <= TOHOST_RESET;
      tohost_wr <= 1'b0;
    end else begin
      tohost_wr <= tohost_we;
      if (tohost_we) begin
        tohost <= wr_data;
      end
    end
  end

  // Reads see register contents before this cycle's write takes effect.
  always_comb begin
    // NOTE: default assignment first so no path leaves csr_rdata unassigned,
    // which would otherwise infer a latch.
    csr_rdata = '0;
    if (csr_addr == TOHOST_ADDR) begin
      csr_rdata = tohost;
    end else begin
      case (csr_addr)
        CSR_CYCLE,  CSR_TIME:  csr_rdata = cycle_cnt[31:0];
        CSR_CYCLEH, CSR_TIMEH: csr_rdata = cycle_cnt[63:32];
        CSR_INSTRET:           csr_rdata = instret_cnt[31:0];
        CSR_INSTRETH:          csr_rdata = instret_cnt[63:32];
        default:               csr_rdata = '0;
      endcase
    end
  end

endmodule
